fixed_sqrt: RTL and testbench

- Iterative fixed-point square root, the forward counterpart of the pipelined inverse square root.
- Computes out = sqrt(in) for a signed Q(B-D).D `fixed` operand, one result bit per cycle.
- Feeds the vector-normalisation and distance paths where 1/sqrt is not what is wanted.
- Uses valid/ready handshakes on both sides so it can sit between pipeline stages with backpressure.

---
 rtl/fixed_sqrt.sv | 144 ++++++++++++++
 tb/tb_fixed_sqrt.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_sqrt.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_sqrt
//  Description : Iterative signed fixed-point square root. The result is
//                floor(sqrt(in)) in the same Q(B-D).D format, one result bit
//                per cycle, with valid/ready handshakes on both sides.
//                Negative radicands return 0 with an error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_sqrt #(
    parameter int B = 20,   // total bits of a fixed value
    parameter int D = 8     // fractional bits; B+D must be even
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic [B-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [B-1:0] out,
    output logic         out_neg_err,
    output logic         out_exact,
    output logic         out_valid,
    input  logic         out_ready
);

    // Derived sizes: W is the radicand width, N the number of result bits.
    localparam int W  = B + D;
    localparam int N  = W / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_CALC     = 2'd1;
    localparam logic [1:0]    c_DONE     = 2'd2;
    localparam logic [CW-1:0] c_LAST_CNT = CW'(N - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [W-1:0]  r_rad;
    logic [N+1:0]  r_rem;
    logic [N-1:0]  r_root;
    logic [CW-1:0] r_cnt;
    logic [B-1:0]  r_out;
    logic          r_neg_err;
    logic          r_exact;

    // One restoring-square-root step. The partial remainder never exceeds
    // 2*root, so r2 always fits in N+2 bits even at the largest radicand.
    logic [N+1:0]  w_r2;
    logic [N+1:0]  w_t;
    logic [N+1:0]  w_diff;
    logic          w_ge;
    logic [N+1:0]  w_rem_next;
    logic [N-1:0]  w_root_next;

    assign w_r2        = (r_rem << 2) | {{N{1'b0}}, r_rad[W-1:W-2]};
    assign w_t         = {r_root, 2'b01};
    assign w_ge        = (w_r2 >= w_t);
    assign w_diff      = w_r2 - w_t;
    assign w_rem_next  = w_ge ? w_diff : w_r2;
    assign w_root_next = (r_root << 1) | {{(N-1){1'b0}}, w_ge};

    assign in_ready    = (r_state == c_IDLE);
    assign out_valid   = (r_state == c_DONE);
    assign out         = r_out;
    assign out_neg_err = r_neg_err;
    assign out_exact   = r_exact;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept in IDLE, iterate N times, hold result until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_next_state = in[B-1] ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Datapath: load on accept, one iteration per CALC cycle, latch result.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_neg_err <= 1'b0;
            r_exact   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (in[B-1]) begin
                            r_out     <= '0;
                            r_neg_err <= 1'b1;
                            r_exact   <= 1'b0;
                        end else begin
                            r_rad  <= {in, {D{1'b0}}};
                            r_rem  <= '0;
                            r_root <= '0;
                            r_cnt  <= '0;
                        end
                    end
                end
                c_CALC: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST_CNT) begin
                        r_out     <= {{(B-N){1'b0}}, w_root_next};
                        r_exact   <= (w_rem_next == '0);
                        r_neg_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_sqrt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fixed_sqrt
//  Description : Self-checking bench for fixed_sqrt against an integer
//                floor-sqrt reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_sqrt;

    localparam int B = 20;
    localparam int D = 8;
    localparam int N = (B + D) / 2;

    logic         clk_in   = 1'b0;
    logic         rst_n_in = 1'b0;
    logic [B-1:0] in       = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic [B-1:0] out;
    logic         out_neg_err;
    logic         out_exact;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    fixed_sqrt #(.B(B), .D(D)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .in          (in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out         (out),
        .out_neg_err (out_neg_err),
        .out_exact   (out_exact),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk_in = ~clk_in;

    // Reference: largest x with x*x <= (v << D), found by binary search.
    function automatic logic [B-1:0] model_root(input logic [B-1:0] v,
                                                output bit exact, output bit neg);
        longint r, lo, hi, mid;
        neg   = v[B-1];
        exact = 1'b0;
        if (neg) return '0;
        r  = longint'(v) << D;
        lo = 0;
        hi = longint'(1) << N;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= r) lo = mid;
            else                hi = mid - 1;
        end
        exact = (lo * lo == r);
        return lo[B-1:0];
    endfunction

    // Present one radicand and hold it for exactly one accepting edge.
    task automatic send(input logic [B-1:0] v);
        @(negedge clk_in);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: got %b expected 1", in_ready);
        end
        in       = v;
        in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        in       = B'($urandom);
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    // Full transaction checked against the model; out_ready assumed high.
    task automatic do_op(input logic [B-1:0] v, input string tag,
                         output logic [B-1:0] got, output logic got_exact);
        logic [B-1:0] eo;
        bit           ee, en;
        int           cyc;
        eo = model_root(v, ee, en);
        send(v);
        wait_valid(cyc);
        checks++;
        if (cyc !== (en ? 0 : N)) begin
            errors++;
            $display("FAIL %s_latency in=%h: got %0d expected %0d", tag, v, cyc, en ? 0 : N);
        end
        checks++;
        if (out !== eo) begin
            errors++;
            $display("FAIL %s_out in=%h: got %h expected %h", tag, v, out, eo);
        end
        checks++;
        if (out_exact !== ee) begin
            errors++;
            $display("FAIL %s_exact in=%h: got %b expected %b", tag, v, out_exact, ee);
        end
        checks++;
        if (out_neg_err !== en) begin
            errors++;
            $display("FAIL %s_neg_err in=%h: got %b expected %b", tag, v, out_neg_err, en);
        end
        got       = out;
        got_exact = out_exact;
        @(posedge clk_in);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== eo) begin
            errors++;
            $display("FAIL %s_single_valid: out_valid=%b out=%h expected 0 and %h",
                     tag, out_valid, out, eo);
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || out_neg_err !== 1'b0 || out_exact !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h valid=%b neg=%b exact=%b expected all 0",
                     out, out_valid, out_neg_err, out_exact);
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [B-1:0] got;
        logic         gx;
        do_op(20'h00400, "four", got, gx);
        checks++;
        if (got !== 20'h00200 || gx !== 1'b1) begin
            errors++;
            $display("FAIL four_literal: got %h/%b expected 00200/1", got, gx);
        end
        do_op(20'h00200, "two", got, gx);
        checks++;
        if (got !== 20'h0016A || gx !== 1'b0) begin
            errors++;
            $display("FAIL two_literal: got %h/%b expected 0016a/0", got, gx);
        end
        do_op(20'h00001, "lsb", got, gx);
        checks++;
        if (got !== 20'h00010 || gx !== 1'b1) begin
            errors++;
            $display("FAIL lsb_literal: got %h/%b expected 00010/1", got, gx);
        end
        do_op(20'h7FFFF, "max", got, gx);
        checks++;
        if (got !== 20'h02D41 || gx !== 1'b0) begin
            errors++;
            $display("FAIL max_literal: got %h/%b expected 02d41/0", got, gx);
        end
        do_op(20'h00000, "zero", got, gx);
        checks++;
        if (got !== 20'h00000 || gx !== 1'b1) begin
            errors++;
            $display("FAIL zero_literal: got %h/%b expected 00000/1", got, gx);
        end
    endtask

    task automatic test_negative();
        logic [B-1:0] got;
        logic         gx;
        do_op(20'hFFF00, "neg", got, gx);
        checks++;
        if (got !== 20'h00000) begin
            errors++;
            $display("FAIL neg_literal: got %h expected 00000", got);
        end
        do_op(20'h01900, "after_neg", got, gx);
        checks++;
        if (got !== 20'h00500 || out_neg_err !== 1'b0) begin
            errors++;
            $display("FAIL after_neg_literal: got %h neg=%b expected 00500/0", got, out_neg_err);
        end
    endtask

    task automatic test_backpressure();
        int           cyc;
        logic [B-1:0] held;
        out_ready = 1'b0;
        send(20'h01900);
        // Radicand input churns while busy; none of it may be sampled.
        in_valid = 1'b1;
        in       = 20'hFFFFF;
        wait_valid(cyc);
        checks++;
        if (cyc !== N || out !== 20'h00500) begin
            errors++;
            $display("FAIL bp_first: latency %0d out %h expected %0d 00500", cyc, out, N);
        end
        held = out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            in = B'($urandom);
            @(posedge clk_in);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== held) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b in_ready=%b out=%h expected 1/0/%h",
                         i, out_valid, in_ready, out, held);
            end
        end
        @(negedge clk_in);
        in        = 20'h00400;
        out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== held) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b out=%h expected 0/1/%h",
                     out_valid, in_ready, out, held);
        end
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: in_ready=%b expected 0", in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== N || out !== 20'h00200 || out_exact !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: latency %0d out %h exact %b expected %0d 00200 1",
                     cyc, out, out_exact, N);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [B-1:0] got;
        logic         gx;
        send(20'h00900);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || out_exact !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: valid=%b out=%h exact=%b expected 0/0/0",
                     out_valid, out, out_exact);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_discard cycle %0d: valid=%b in_ready=%b expected 0/1",
                         i, out_valid, in_ready);
            end
        end
        do_op(20'h00900, "nine", got, gx);
        checks++;
        if (got !== 20'h00300) begin
            errors++;
            $display("FAIL nine_literal: got %h expected 00300", got);
        end
    endtask

    task automatic test_random();
        logic [B-1:0] v, got;
        logic         gx;
        for (int i = 0; i < 40; i++) begin
            v = B'($urandom);
            if (i % 4 != 3) v[B-1] = 1'b0;
            if (i % 8 == 5) v = B'($urandom_range(0, 255));
            do_op(v, "rand", got, gx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_negative();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
